// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus and registered register-file write port for rf_wb_arbiter.
// master = requester/register-file side, slave = arbiter side.
interface rf_wb_arbiter_if #(
    parameter int unsigned NREQ = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*5-1:0]  req_wa;
    logic [NREQ*32-1:0] req_wd;
    logic               rf_wen;
    logic [4:0]         rf_wa;
    logic [31:0]        rf_wd;

    modport master (
        output req_valid, req_wa, req_wd,
        input  req_ready, rf_wen, rf_wa, rf_wd
    );

    modport slave (
        input  req_valid, req_wa, req_wd,
        output req_ready, rf_wen, rf_wa, rf_wd
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter with a registered register-file write port.
// Optional busy-register scoreboard and RAW hazard check under RF_WB_SCOREBOARD_EN.
module rf_wb_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    rf_wb_arbiter_if.slave     bus,
    input  logic               iss_valid,
    input  logic [4:0]         iss_rd,
    input  logic               flush,
    input  logic [4:0]         chk_rs1,
    input  logic [4:0]         chk_rs2,
    output logic               hazard,
    output logic [31:0]        busy_vec
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   scan;
    logic            gnt_any;
    logic [NREQ-1:0] grant;
    logic [4:0]      gnt_wa;
    logic [31:0]     gnt_wd;

    // Search upward from rr_ptr with wrap; first valid requester wins.
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_wa  = '0;
        gnt_wd  = '0;
        scan    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan = PW'((32'(rr_ptr) + k) % NREQ);
            if (!gnt_any && bus.req_valid[scan]) begin
                gnt_any = 1'b1;
                gnt_idx = scan;
                gnt_wa  = bus.req_wa[32'(scan)*5 +: 5];
                gnt_wd  = bus.req_wd[32'(scan)*32 +: 32];
            end
        end
        // Grants are suppressed while reset is held so req_ready reads 0 asynchronously.
        if (!rst_n) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign bus.req_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            bus.rf_wen <= 1'b0;
            bus.rf_wa  <= '0;
            bus.rf_wd  <= '0;
        end else begin
            bus.rf_wen <= gnt_any && (gnt_wa != 5'd0);
            if (gnt_any) begin
                rr_ptr    <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                bus.rf_wa <= gnt_wa;
                bus.rf_wd <= gnt_wd;
            end
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    logic [31:0] busy;
    logic [31:0] busy_nxt;

    // Clear from the retiring write first so a same-cycle issue to that register wins.
    always_comb begin
        busy_nxt = busy;
        if (bus.rf_wen) begin
            busy_nxt[bus.rf_wa] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;
    assign hazard   = ((chk_rs1 != 5'd0) && busy[chk_rs1]) ||
                      ((chk_rs2 != 5'd0) && busy[chk_rs2]);
`else
    logic sb_unused;

    assign sb_unused = ^{iss_valid, iss_rd, flush, chk_rs1, chk_rs2};
    assign busy_vec  = '0;
    assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: reference model of arbitration, write port
// and scoreboard, with expected writes queued at grant time and compared one cycle later.
module tb_rf_wb_arbiter;
`ifdef RF_WB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    typedef struct packed {
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        flush;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        hazard;
    logic [31:0] busy_vec;

    rf_wb_arbiter_if #(.NREQ(3)) bus ();

    rf_wb_arbiter #(.NREQ(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .flush    (flush),
        .chk_rs1  (chk_rs1),
        .chk_rs2  (chk_rs2),
        .hazard   (hazard),
        .busy_vec (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    wr_t         exp_q[$];
    logic [2:0]  pend;
    logic [2:0]  keep;
    logic [4:0]  wa_t[3];
    logic [31:0] wd_t[3];
    int          rr_m;
    int          last_gnt;
    wr_t         m_cur;
    logic [31:0] busy_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid = pend;
        for (int i = 0; i < 3; i++) begin
            bus.req_wa[i*5 +: 5]   = wa_t[i];
            bus.req_wd[i*32 +: 32] = wd_t[i];
        end
    endtask

    task automatic model_reset();
        rr_m   = 0;
        m_cur  = '0;
        busy_m = '0;
        exp_q.delete();
    endtask

    // One clock: check grant/scoreboard mid-cycle, queue expected write, compare after edge.
    task automatic step();
        int          gi;
        logic [2:0]  g;
        logic [31:0] nb;
        logic        h;
        wr_t         e;
        wr_t         got;
        @(negedge clk);
        gi = -1;
        g  = '0;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (rr_m + k) % 3;
            if (gi < 0 && pend[idx]) gi = idx;
        end
        if (gi >= 0) g[gi] = 1'b1;
        check_eq("req_ready", 32'(bus.req_ready), 32'(g));
        h = ((chk_rs1 != 0) && busy_m[chk_rs1]) || ((chk_rs2 != 0) && busy_m[chk_rs2]);
        check_eq("busy_vec", busy_vec, SB_EN ? busy_m : 32'd0);
        check_eq("hazard", 32'(hazard), SB_EN ? 32'(h) : 32'd0);
        if (gi >= 0) e = '{wen: (wa_t[gi] != 0), wa: wa_t[gi], wd: wd_t[gi]};
        else         e = '{wen: 1'b0, wa: m_cur.wa, wd: m_cur.wd};
        exp_q.push_back(e);
        nb = busy_m;
        if (m_cur.wen) nb[m_cur.wa] = 1'b0;
        if (iss_valid && iss_rd != 0) nb[iss_rd] = 1'b1;
        if (flush) nb = '0;
        nb[0] = 1'b0;
        @(posedge clk);
        #1;
        got = '{wen: bus.rf_wen, wa: bus.rf_wa, wd: bus.rf_wd};
        e = exp_q.pop_front();
        check_eq("rf_wen", 32'(got.wen), 32'(e.wen));
        check_eq("rf_wa", 32'(got.wa), 32'(e.wa));
        check_eq("rf_wd", got.wd, e.wd);
        m_cur    = e;
        busy_m   = nb;
        last_gnt = gi;
        if (gi >= 0) begin
            rr_m = (gi + 1) % 3;
            if (!keep[gi]) pend[gi] = 1'b0;
        end
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
        chk_rs1 = '0; chk_rs2 = '0;
        pend = '0; keep = '0;
        for (int i = 0; i < 3; i++) begin wa_t[i] = '0; wd_t[i] = '0; end
        drive();
        model_reset();
        last_gnt = -1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rf_wen", 32'(bus.rf_wen), 32'd0);
        check_eq("rst_rf_wa", 32'(bus.rf_wa), 32'd0);
        check_eq("rst_rf_wd", bus.rf_wd, 32'd0);
        check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst_busy", busy_vec, 32'd0);
        check_eq("rst_hazard", 32'(hazard), 32'd0);
        rst_n = 1'b1;

        // Round-robin with all three requesters continuously valid.
        for (int i = 0; i < 3; i++) begin wa_t[i] = 5'(i + 1); wd_t[i] = 32'h1000 + 32'(i); end
        pend = 3'b111; keep = 3'b111; drive();
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("rr_order", 32'(last_gnt), 32'(i % 3));
        end
        pend = '0; keep = '0; drive();
        step();

        // Pointer holds across idle cycles.
        pend[1] = 1'b1; wa_t[1] = 5'd4; wd_t[1] = 32'hA5A5_0004; drive();
        step();
        check_eq("hold_g1", 32'(last_gnt), 32'd1);
        repeat (3) step();
        pend[0] = 1'b1; wa_t[0] = 5'd6; wd_t[0] = 32'h0000_0006;
        pend[2] = 1'b1; wa_t[2] = 5'd7; wd_t[2] = 32'h0000_0007; drive();
        step();
        check_eq("hold_g2", 32'(last_gnt), 32'd2);
        step();
        check_eq("hold_g0", 32'(last_gnt), 32'd0);

        // x0 write accepted and dropped.
        pend[0] = 1'b1; wa_t[0] = 5'd0; wd_t[0] = 32'hDEADBEEF; drive();
        step();
        check_eq("x0_grant", 32'(last_gnt), 32'd0);
        step();

        // Scoreboard set, clear by writeback, and set-wins-over-clear.
        iss_valid = 1'b1; iss_rd = 5'd5;
        step();
        iss_valid = 1'b0; chk_rs1 = 5'd5;
        #1 check_eq("haz_set", 32'(hazard), 32'(SB_EN));
        pend[1] = 1'b1; wa_t[1] = 5'd5; wd_t[1] = 32'h5555_5555; drive();
        step();
        step();
        #1 check_eq("haz_clr", 32'(hazard), 32'd0);
        iss_valid = 1'b1; iss_rd = 5'd5;
        step();
        iss_valid = 1'b0;
        pend[1] = 1'b1; drive();
        step();
        iss_valid = 1'b1; iss_rd = 5'd5;
        step();
        iss_valid = 1'b0;
        check_eq("set_wins", 32'(busy_vec[5]), 32'(SB_EN));

        // Flush overrides a same-cycle issue.
        for (int r = 4; r < 8; r++) begin
            iss_valid = 1'b1; iss_rd = 5'(r);
            step();
        end
        iss_valid = 1'b0;
        check_eq("busy_f0", busy_vec, SB_EN ? 32'h0000_00F0 : 32'd0);
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        flush = 1'b0; iss_valid = 1'b0;
        check_eq("flush_clr", busy_vec, 32'd0);

        // Reset mid-operation drops the in-flight write and restarts at requester 0.
        pend[1] = 1'b1; wa_t[1] = 5'd8; wd_t[1] = 32'h0000_0088;
        iss_valid = 1'b1; iss_rd = 5'd5; chk_rs1 = 5'd5; drive();
        step();
        iss_valid = 1'b0;
        check_eq("pre_rst_g1", 32'(last_gnt), 32'd1);
        pend[2] = 1'b1; wa_t[2] = 5'd9; wd_t[2] = 32'h0000_0099; drive();
        @(negedge clk);
        check_eq("pre_rst_ready", 32'(bus.req_ready), 32'b100);
        check_eq("pre_rst_haz", 32'(hazard), 32'(SB_EN));
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_ready", 32'(bus.req_ready), 32'd0);
        check_eq("arst_wen", 32'(bus.rf_wen), 32'd0);
        check_eq("arst_wa", 32'(bus.rf_wa), 32'd0);
        check_eq("arst_busy", busy_vec, 32'd0);
        check_eq("arst_haz", 32'(hazard), 32'd0);
        @(posedge clk);
        #1;
        check_eq("arst_wen_edge", 32'(bus.rf_wen), 32'd0);
        pend[0] = 1'b1; wa_t[0] = 5'd10; wd_t[0] = 32'h0000_00AA; drive();
        model_reset();
        rst_n = 1'b1;
        check_eq("rel_wen", 32'(bus.rf_wen), 32'd0);
        step();
        check_eq("rel_first_g0", 32'(last_gnt), 32'd0);
        step();
        check_eq("rel_then_g2", 32'(last_gnt), 32'd2);
        chk_rs1 = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3: number of writeback requesters, index 0 = ALU, 1 = LSU, 2 = MUL/DIV.
REQ-002 The block SHALL have port clk, input, 1: sole clock; all state updates on posedge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port req_valid, input, NREQ: per-requester writeback request.
REQ-005 The block SHALL have port req_ready, output, NREQ: per-requester grant; transfer when valid & ready.
REQ-006 The block SHALL have port req_wa, input, NREQ*5: destination register per requester; requester i uses bits [5i+4:5i].
REQ-007 The block SHALL have port req_wd, input, NREQ*32: write data per requester; requester i uses bits [32i+31:32i].
REQ-008 The block SHALL have ports rf_wen, rf_wa and rf_wd, outputs of 1, 5 and 32 bits: registered register-file write port.
REQ-009 The block SHALL have ports iss_valid, input, 1, and iss_rd, input, 5: instruction issue with destination register.
REQ-010 The block SHALL have port flush, input, 1: pipeline flush; clears the scoreboard.
REQ-011 The block SHALL have ports chk_rs1 and chk_rs2, inputs, 5 each: source registers to hazard-check.
REQ-012 The block SHALL have ports hazard, output, 1, and busy_vec, output, 32: RAW hazard flag and pending-write bitmap.

Function
REQ-013 At most one req_ready bit SHALL be high per cycle, and only for a requester whose req_valid is high.
REQ-014 Arbitration SHALL be round-robin: search starts at pointer rr_ptr and proceeds upward with wrap NREQ-1 -> 0; the first valid requester found is granted.
REQ-015 After a grant to requester i, rr_ptr SHALL become (i+1) mod NREQ; with no grant, rr_ptr SHALL hold.
REQ-016 Requesters SHALL hold valid, wa and wd stable until granted; the block SHALL NOT buffer ungranted requests.
REQ-017 A grant in cycle N SHALL produce rf_wen=1, rf_wa=wa, rf_wd=wd in cycle N+1, for a latency of exactly 1 cycle, at a rate of 1 write per cycle.
REQ-018 A granted request with wa=0 SHALL be accepted and SHALL drive rf_wen=0 in cycle N+1; x0 writes are dropped.
REQ-019 With no grant, rf_wen SHALL be 0 next cycle, and rf_wa/rf_wd SHALL hold their previous values.
REQ-020 iss_valid with iss_rd!=0 SHALL set busy_vec[iss_rd] at the next edge; iss_rd=0 SHALL be ignored.
REQ-021 rf_wen=1 SHALL clear busy_vec[rf_wa] at the end of that cycle.
REQ-022 A simultaneous set and clear of the same bit SHALL result in set, because the issue is younger.
REQ-023 flush SHALL clear all busy bits at the next edge, and flush SHALL override a same-cycle iss_valid; grants and the write port SHALL be unaffected by flush.
REQ-024 hazard SHALL be combinational: (chk_rs1!=0 & busy_vec[chk_rs1]) | (chk_rs2!=0 & busy_vec[chk_rs2]).
REQ-025 busy_vec[0] SHALL always be 0.

Reset
REQ-026 While rst_n=0, the block SHALL hold rf_wen=0, rf_wa=0, rf_wd=0, rr_ptr=0, busy_vec=0, req_ready=0 and hazard=0, asynchronously.
REQ-027 Reset asserted mid-operation SHALL discard any in-flight write: no rf_wen pulse SHALL follow deassertion without a new grant.
REQ-028 The first grant after reset SHALL start its search at requester 0.

Configuration
REQ-029 Macro RF_WB_SCOREBOARD_EN, when defined, SHALL include the busy_vec scoreboard and hazard logic per REQ-020 to REQ-025.
REQ-030 When RF_WB_SCOREBOARD_EN is undefined, busy_vec and hazard SHALL be tied to 0, iss_valid/iss_rd/flush/chk_rs* SHALL be ignored, and arbitration and the write port SHALL be unchanged.

Verification
REQ-031 The bench SHALL cover round-robin: all three valid continuously with wa=1,2,3 -> grants 0,1,2,0,1,2, and rf_wa sequence 1,2,3,1,... each one cycle after its grant.
REQ-032 The bench SHALL cover pointer hold: grant to 1, then idle 3 cycles, then valid on 0 and 2 -> grant to 2 first, then 0.
REQ-033 The bench SHALL cover the x0 drop: requester 0 with wa=0, wd=32'hDEADBEEF -> req_ready[0]=1 and rf_wen=0 next cycle.
REQ-034 The bench SHALL cover scoreboard: iss rd=5, then chk_rs1=5 -> hazard=1; write to 5 granted -> hazard=0 two cycles later; iss rd=5 in the same cycle rf_wen clears 5 -> busy_vec[5] stays 1.
REQ-035 The bench SHALL cover flush and reset: busy_vec=32'h0000_00F0 with flush=1 and iss rd=9 -> busy_vec=0; rst_n low the cycle after a grant -> no rf_wen pulse, and the first grant after release goes to requester 0.
